// File: rtl/fixed_point_pkg.sv
// Signed fixed-point type shared by the perceptron stage and its sequencer.
// sfp is Q8.8 two's complement; int_to_sfp converts a whole number.
package FixedPoint;

  localparam int SFP_W    = 16;
  localparam int SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  function automatic sfp int_to_sfp(input int v);
    return sfp'(v <<< SFP_FRAC);
  endfunction

endpackage

// File: rtl/perceptron_seq_pkg.sv
// Shared types for the perceptron training sequencer: FSM states and the
// stored sample record. SEQ_INPUT_UNITS fixes the sample width and must
// equal the sequencer's INPUT_UNITS parameter.
package perceptron_seq_pkg;

  import FixedPoint::*;

  localparam int SEQ_INPUT_UNITS = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRAIN  = 3'd1,
    EVAL   = 3'd2,
    NEXT   = 3'd3,
    FINISH = 3'd4
  } seq_state_e;

  typedef struct packed {
    sfp [SEQ_INPUT_UNITS-1:0] values;
    sfp                       expected;
  } sample_t;

endpackage

// File: rtl/perceptron_sample_store.sv
// Dataset register file: MAX_SAMPLES labelled samples, cleared by reset,
// one synchronous write port and one combinational read port.
module perceptron_sample_store
  import perceptron_seq_pkg::*;
#(
  parameter int MAX_SAMPLES = 8,
  parameter int AW          = $clog2(MAX_SAMPLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  sample_t       wr_data,
  input  logic [AW-1:0] rd_addr,
  output sample_t       rd_data
);

  sample_t mem_r [MAX_SAMPLES];

  // Storage: wiped on reset, otherwise written one entry at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_SAMPLES; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/perceptron_train_sequencer.sv
// Perceptron training sequencer. Streams the stored dataset to the
// perceptron once in training mode and once in evaluation mode per epoch,
// scoring the evaluation pass.
//
// Optional build macro PERCEPTRON_EARLY_STOP_EN: stop the run after the
// first epoch whose evaluation pass scores every sample correct.
//
// Timing (N samples, E epochs run): each epoch costs N*(TRAIN_HOLD +
// PRED_LATENCY + 1) cycles plus one NEXT cycle. Counting the start cycle
// as cycle 0, done is high in cycle E*(N*(TRAIN_HOLD+PRED_LATENCY+1)+1)+2;
// the extra two cycles are the FINISH state and the registered done.
// A zero-length run therefore shows done in cycle 2.
module perceptron_train_sequencer
  import FixedPoint::*;
  import perceptron_seq_pkg::*;
#(
  parameter int INPUT_UNITS  = SEQ_INPUT_UNITS,
  parameter int MAX_SAMPLES  = 8,
  parameter int TRAIN_HOLD   = 2,
  parameter int PRED_LATENCY = 1,
  parameter int EPOCH_W      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [$clog2(MAX_SAMPLES)-1:0]   wr_addr,
  input  sfp                               wr_values [INPUT_UNITS],
  input  sfp                               wr_expected,
  input  logic [$clog2(MAX_SAMPLES+1)-1:0] num_samples,
  input  logic [EPOCH_W-1:0]               max_epochs,
  input  sfp                               lr_cfg,
  input  logic                             start,
  input  sfp                               prediction,
  output sfp                               values [INPUT_UNITS],
  output sfp                               expected,
  output logic                             training,
  output sfp                               learning_rate,
  output logic                             busy,
  output logic                             done,
  output logic [EPOCH_W-1:0]               epoch,
  output logic [$clog2(MAX_SAMPLES+1)-1:0] correct_count,
  output logic                             all_correct
);

  localparam int AW       = $clog2(MAX_SAMPLES);
  localparam int CW       = $clog2(MAX_SAMPLES+1);
  localparam int HOLD_MAX = (TRAIN_HOLD > PRED_LATENCY + 1) ? TRAIN_HOLD : PRED_LATENCY + 1;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [HW-1:0] TRAIN_LAST = HW'(TRAIN_HOLD - 1);
  localparam logic [HW-1:0] EVAL_LAST  = HW'(PRED_LATENCY);

  // Control state
  seq_state_e         state_r, state_nx_s;
  logic [CW-1:0]      idx_r, idx_nx_s;
  logic [HW-1:0]      hold_r, hold_nx_s;
  logic [CW-1:0]      tally_r, tally_nx_s;
  logic [EPOCH_W-1:0] epoch_r, epoch_nx_s;
  logic [CW-1:0]      num_r;
  logic [EPOCH_W-1:0] maxep_r;
  sfp                 lr_r;
  logic               latch_s;
  logic               eval_done_s;

  // Registered outputs
  sfp                 values_r [INPUT_UNITS];
  sfp                 expected_r;
  logic               training_r;
  logic               busy_r;
  logic               done_r;
  logic [CW-1:0]      correct_count_r;
  logic               all_correct_r;

  // Derived terms
  logic [CW-1:0]      num_clamp_s;
  logic [CW-1:0]      last_idx_s;
  logic [EPOCH_W-1:0] epoch_inc_s;
  logic               zero_run_s;
  logic               match_s;
  logic               stop_s;
  logic               store_wr_en_s;
  sample_t            wr_sample_s;
  sample_t            rd_sample_s;

  assign num_clamp_s = (num_samples > CW'(MAX_SAMPLES)) ? CW'(MAX_SAMPLES) : num_samples;
  assign zero_run_s  = (num_samples == CW'(0)) || (max_epochs == EPOCH_W'(0));
  assign last_idx_s  = num_r - CW'(1);
  assign epoch_inc_s = epoch_r + EPOCH_W'(1);
  assign match_s     = (prediction == expected_r);

`ifdef PERCEPTRON_EARLY_STOP_EN
  assign stop_s = (epoch_inc_s == maxep_r) || all_correct_r;
`else
  assign stop_s = (epoch_inc_s == maxep_r);
`endif

  // Writes are only taken in IDLE; a write coinciding with start is dropped
  // so the first presented sample can never be a stale read.
  assign store_wr_en_s = wr_en && (state_r == IDLE) && !start;

  // Pack the write-port sample record.
  always_comb begin
    wr_sample_s = '0;
    for (int k = 0; k < INPUT_UNITS; k++) begin
      wr_sample_s.values[k] = wr_values[k];
    end
    wr_sample_s.expected = wr_expected;
  end

  perceptron_sample_store #(
    .MAX_SAMPLES (MAX_SAMPLES),
    .AW          (AW)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store_wr_en_s),
    .wr_addr (wr_addr),
    .wr_data (wr_sample_s),
    .rd_addr (idx_nx_s[AW-1:0]),
    .rd_data (rd_sample_s)
  );

  // Next-state, sample index, hold counter, tally and epoch sequencing.
  always_comb begin
    state_nx_s  = state_r;
    idx_nx_s    = idx_r;
    hold_nx_s   = hold_r;
    tally_nx_s  = tally_r;
    epoch_nx_s  = epoch_r;
    latch_s     = 1'b0;
    eval_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          latch_s    = 1'b1;
          idx_nx_s   = CW'(0);
          hold_nx_s  = HW'(0);
          tally_nx_s = CW'(0);
          epoch_nx_s = EPOCH_W'(0);
          if (zero_run_s) begin
            state_nx_s = FINISH;
          end else begin
            state_nx_s = TRAIN;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      TRAIN: begin
        if (hold_r == TRAIN_LAST) begin
          hold_nx_s = HW'(0);
          if (idx_r == last_idx_s) begin
            idx_nx_s   = CW'(0);
            tally_nx_s = CW'(0);
            state_nx_s = EVAL;
          end else begin
            idx_nx_s = idx_r + CW'(1);
          end
        end else begin
          hold_nx_s = hold_r + HW'(1);
        end
      end
      EVAL: begin
        // The prediction for the presented sample is valid on the last hold cycle.
        if (hold_r == EVAL_LAST) begin
          hold_nx_s  = HW'(0);
          tally_nx_s = tally_r + (match_s ? CW'(1) : CW'(0));
          if (idx_r == last_idx_s) begin
            idx_nx_s    = CW'(0);
            eval_done_s = 1'b1;
            state_nx_s  = NEXT;
          end else begin
            idx_nx_s = idx_r + CW'(1);
          end
        end else begin
          hold_nx_s = hold_r + HW'(1);
        end
      end
      NEXT: begin
        epoch_nx_s = epoch_inc_s;
        idx_nx_s   = CW'(0);
        hold_nx_s  = HW'(0);
        if (stop_s) begin
          state_nx_s = FINISH;
        end else begin
          state_nx_s = TRAIN;
        end
      end
      FINISH: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Control registers and run configuration latched on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= CW'(0);
      hold_r  <= HW'(0);
      tally_r <= CW'(0);
      epoch_r <= EPOCH_W'(0);
      num_r   <= CW'(0);
      maxep_r <= EPOCH_W'(0);
      lr_r    <= sfp'(0);
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      hold_r  <= hold_nx_s;
      tally_r <= tally_nx_s;
      epoch_r <= epoch_nx_s;
      if (latch_s) begin
        num_r   <= num_clamp_s;
        maxep_r <= max_epochs;
        lr_r    <= lr_cfg;
      end
    end
  end

  // Output registers, loaded from the upcoming state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < INPUT_UNITS; k++) begin
        values_r[k] <= sfp'(0);
      end
      expected_r      <= sfp'(0);
      training_r      <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      correct_count_r <= CW'(0);
      all_correct_r   <= 1'b0;
    end else begin
      training_r <= (state_nx_s == TRAIN);
      busy_r     <= (state_nx_s != IDLE);
      done_r     <= (state_r == FINISH);
      if ((state_nx_s == TRAIN) || (state_nx_s == EVAL)) begin
        for (int k = 0; k < INPUT_UNITS; k++) begin
          values_r[k] <= rd_sample_s.values[k];
        end
        expected_r <= rd_sample_s.expected;
      end else if (state_nx_s != NEXT) begin
        for (int k = 0; k < INPUT_UNITS; k++) begin
          values_r[k] <= sfp'(0);
        end
        expected_r <= sfp'(0);
      end
      if (latch_s) begin
        correct_count_r <= CW'(0);
        all_correct_r   <= 1'b0;
      end else if (eval_done_s) begin
        correct_count_r <= tally_nx_s;
        all_correct_r   <= (tally_nx_s == num_r);
      end
    end
  end

  assign values        = values_r;
  assign expected      = expected_r;
  assign training      = training_r;
  assign learning_rate = lr_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign epoch         = epoch_r;
  assign correct_count = correct_count_r;
  assign all_correct   = all_correct_r;

endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// Directed bench for perceptron_train_sequencer with a small behavioural
// perceptron (integer weights, registered prediction one cycle after the
// sample) or an always-zero stub.
module tb_perceptron_train_sequencer;
  import FixedPoint::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  sfp         wr_values [2];
  sfp         wr_expected = 16'sd0;
  logic [3:0] num_samples = 4'd0;
  logic [7:0] max_epochs = 8'd0;
  sfp         lr_cfg = 16'sd0;
  logic       start = 1'b0;
  sfp         prediction;
  sfp         values [2];
  sfp         expected;
  logic       training, busy, done, all_correct;
  sfp         learning_rate;
  logic [7:0] epoch;
  logic [3:0] correct_count;

  int vectors = 0;
  int miscompares = 0;

  sfp m_vals [8][2];
  sfp m_lab [8];

  bit stub_zero = 1'b1;
  int w0, w1, wb;
  int x0, x1, s_m, y_m, t_m, lr_m, err_m;

  always #5 clk = ~clk;

  perceptron_train_sequencer #(
    .INPUT_UNITS(2), .MAX_SAMPLES(8), .TRAIN_HOLD(2), .PRED_LATENCY(1), .EPOCH_W(8)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_values(wr_values),
    .wr_expected(wr_expected), .num_samples(num_samples), .max_epochs(max_epochs),
    .lr_cfg(lr_cfg), .start(start), .prediction(prediction), .values(values),
    .expected(expected), .training(training), .learning_rate(learning_rate),
    .busy(busy), .done(done), .epoch(epoch), .correct_count(correct_count),
    .all_correct(all_correct)
  );

  // Perceptron model: threshold unit, update rule w += lr*(t-y)*x every training cycle.
  always_comb begin
    x0 = int'(values[0]) >>> 8;
    x1 = int'(values[1]) >>> 8;
    t_m = int'(expected) >>> 8;
    lr_m = int'(learning_rate) >>> 8;
    s_m = w0 * x0 + w1 * x1 + wb;
    if (s_m > 0) y_m = 1; else y_m = 0;
    err_m = t_m - y_m;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      prediction <= 16'sd0; w0 <= 0; w1 <= 0; wb <= 0;
    end else if (start && !busy) begin
      prediction <= 16'sd0; w0 <= 0; w1 <= 0; wb <= 0;
    end else begin
      prediction <= (stub_zero || y_m == 0) ? 16'sd0 : int_to_sfp(1);
      if (training) begin
        w0 <= w0 + lr_m * err_m * x0;
        w1 <= w1 + lr_m * err_m * x1;
        wb <= wb + lr_m * err_m;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic wr_sample(input int a, input int v0, input int v1, input int lab);
    logic [2:0] a3;
    a3 = a[2:0];
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a3;
    wr_values[0] = int_to_sfp(v0); wr_values[1] = int_to_sfp(v1); wr_expected = int_to_sfp(lab);
    m_vals[a][0] = int_to_sfp(v0); m_vals[a][1] = int_to_sfp(v1); m_lab[a] = int_to_sfp(lab);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_and();
    wr_sample(0, 0, 0, 0);
    wr_sample(1, 0, 1, 0);
    wr_sample(2, 1, 0, 0);
    wr_sample(3, 1, 1, 1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      m_vals[i][0] = 16'sd0; m_vals[i][1] = 16'sd0; m_lab[i] = 16'sd0;
    end
  endtask

  // Start a run; cycle n=1 is the cycle after start. Optionally checks the
  // first epoch's presentation order (seq_n samples) and injects misuse at n=5.
  task automatic run_seq(input logic [3:0] ns, input logic [7:0] me, input sfp lr,
                         input int seq_n, input bit misuse,
                         output int done_cyc, output int done_cnt, output int train_cyc);
    int n, j, idx;
    logic tr;
    @(negedge clk);
    num_samples = ns; max_epochs = me; lr_cfg = lr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; done_cyc = 0; done_cnt = 0; train_cyc = 0;
    while (n < 600) begin
      if (n == 1) check_eq("busy_after_start", busy, 1);
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = n;
          check_eq("busy_at_done", busy, 0);
          check_eq("done_values0", values[0], 0);
          check_eq("done_expected", expected, 0);
          check_eq("done_training", training, 0);
        end
      end
      if (training) train_cyc++;
      if (seq_n > 0 && n <= 4 * seq_n) begin
        j = n - 1;
        if (j < 2 * seq_n) begin idx = j / 2; tr = 1'b1; end
        else begin idx = (j - 2 * seq_n) / 2; tr = 1'b0; end
        check_eq("seq_values0", values[0], m_vals[idx][0]);
        check_eq("seq_values1", values[1], m_vals[idx][1]);
        check_eq("seq_expected", expected, m_lab[idx]);
        check_eq("seq_training", training, tr);
      end
      if (misuse && n == 5) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0;
        wr_values[0] = int_to_sfp(5); wr_values[1] = int_to_sfp(6); wr_expected = int_to_sfp(7);
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (done_cyc != 0 && n >= done_cyc + 3) break;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc, dn, tc;
    wr_values[0] = 16'sd0; wr_values[1] = 16'sd0;
    clear_model();
    #1 rst = 1'b1;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_training", training, 0);
    check_eq("rst_values0", values[0], 0);
    check_eq("rst_values1", values[1], 0);
    check_eq("rst_expected", expected, 0);
    check_eq("rst_lr", learning_rate, 0);
    check_eq("rst_epoch", epoch, 0);
    check_eq("rst_correct", correct_count, 0);
    check_eq("rst_all_correct", all_correct, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    load_and();

    // Stub predicting 0, two epochs, with start/wr_en misuse mid-run.
    stub_zero = 1'b1;
    run_seq(4'd4, 8'd2, int_to_sfp(2), 4, 1'b1, dc, dn, tc);
    check_eq("stub_done_count", dn, 1);
    check_eq("stub_done_cycle", dc, 36);
    check_eq("stub_train_cycles", tc, 16);
    check_eq("stub_correct", correct_count, 3);
    check_eq("stub_all_correct", all_correct, 0);
    check_eq("stub_epoch", epoch, 2);
    check_eq("stub_lr", learning_rate, int_to_sfp(2));

    // num_samples above MAX_SAMPLES clamps to 8; entries 4..7 are zero.
    run_seq(4'd15, 8'd1, int_to_sfp(2), 8, 1'b0, dc, dn, tc);
    check_eq("clamp_done_cycle", dc, 35);
    check_eq("clamp_train_cycles", tc, 16);
    check_eq("clamp_correct", correct_count, 7);
    check_eq("clamp_all_correct", all_correct, 0);

    // Learning AND with the model perceptron.
    stub_zero = 1'b0;
    run_seq(4'd4, 8'd10, int_to_sfp(1), 4, 1'b0, dc, dn, tc);
    check_eq("and_done_count", dn, 1);
    check_eq("and_correct", correct_count, 4);
    check_eq("and_all_correct", all_correct, 1);
    check_eq("and_lr", learning_rate, int_to_sfp(1));
`ifdef PERCEPTRON_EARLY_STOP_EN
    check_eq("and_es_epoch_below_max", (epoch < 8'd10), 1);
`else
    check_eq("and_epoch", epoch, 10);
    check_eq("and_done_cycle", dc, 172);
    check_eq("and_train_cycles", tc, 80);
`endif

    // Zero-length runs.
    run_seq(4'd0, 8'd5, int_to_sfp(1), 0, 1'b0, dc, dn, tc);
    check_eq("zero_ns_done_cycle", dc, 2);
    check_eq("zero_ns_done_count", dn, 1);
    check_eq("zero_ns_correct", correct_count, 0);
    check_eq("zero_ns_all_correct", all_correct, 0);
    check_eq("zero_ns_epoch", epoch, 0);
    run_seq(4'd4, 8'd0, int_to_sfp(1), 0, 1'b0, dc, dn, tc);
    check_eq("zero_me_done_cycle", dc, 2);
    check_eq("zero_me_correct", correct_count, 0);
    check_eq("zero_me_train_cycles", tc, 0);

    // Reset in the middle of the first evaluation pass.
    @(negedge clk);
    num_samples = 4'd4; max_epochs = 8'd10; lr_cfg = int_to_sfp(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check_eq("mid_eval_training", training, 0);
    check_eq("mid_eval_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_training", training, 0);
    check_eq("mrst_values0", values[0], 0);
    check_eq("mrst_values1", values[1], 0);
    check_eq("mrst_expected", expected, 0);
    check_eq("mrst_lr", learning_rate, 0);
    check_eq("mrst_epoch", epoch, 0);
    check_eq("mrst_done", done, 0);
    clear_model();
    repeat (2) begin
      @(negedge clk);
      check_eq("mrst_no_done", done, 0);
    end
    rst = 1'b0;

    // Storage was cleared: stub sees all-zero samples and scores 4/4.
    stub_zero = 1'b1;
    run_seq(4'd4, 8'd1, int_to_sfp(1), 4, 1'b0, dc, dn, tc);
    check_eq("cleared_done_cycle", dc, 19);
    check_eq("cleared_correct", correct_count, 4);
    check_eq("cleared_all_correct", all_correct, 1);
    check_eq("cleared_epoch", epoch, 1);

    // A normal run after reset.
    load_and();
    stub_zero = 1'b0;
    run_seq(4'd4, 8'd10, int_to_sfp(1), 4, 1'b0, dc, dn, tc);
    check_eq("rerun_done_count", dn, 1);
    check_eq("rerun_correct", correct_count, 4);
    check_eq("rerun_all_correct", all_correct, 1);
`ifdef PERCEPTRON_EARLY_STOP_EN
    check_eq("rerun_es_epoch_below_max", (epoch < 8'd10), 1);
`else
    check_eq("rerun_epoch", epoch, 10);
    check_eq("rerun_done_cycle", dc, 172);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
